execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameters: DATA_WIDTH, 32, datapath width; ROM_WIDTH, 12, PC width; RF_WIDTH, 5, register address width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 E-stage inputs, all from the decode/execute register:
  - regWriteE (1), resultSelE (2), memWriteE (1), _pcSelE (2), aluCtrlE (4), aluSelE (1)
  - dout1E / dout2E (DATA_WIDTH), pcE (ROM_WIDTH), regAddr3E (RF_WIDTH), immExtE (DATA_WIDTH)
  - branchE (1), memCtrlE (3), isMulE (1)
REQ-006 fwdAE / fwdBE  in  2  operand forwarding select: 0 = dout1E/dout2E, 1 = aluResultM, 2 = resultW, 3 = reserved, treated as 0.
REQ-007 resultW  in  DATA_WIDTH  writeback-stage result.
REQ-008 pcSrcE  out  1  redirect fetch (combinational).
REQ-009 pcTargetE  out  ROM_WIDTH  redirect target (combinational).
REQ-010 stallMul  out  1  freeze IF/ID/E registers (combinational).
REQ-011 M-stage outputs, all registered:
  - regWriteM (1), resultSelM (2), memWriteM (1), memCtrlM (3)
  - aluResultM (DATA_WIDTH), writeDataM (DATA_WIDTH), regAddr3M (RF_WIDTH), pcPlus4M (ROM_WIDTH)

Function
REQ-012 Operand selection: srcA = fwdAE-selected value; fwdB = fwdBE-selected value; srcB = aluSelE ? immExtE : fwdB; writeDataM captures fwdB.
REQ-013 aluCtrlE encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS-B; 11-15 yield 0.
  - Shifts use srcB[4:0]; all arithmetic wraps mod 2^32.
REQ-014 Branch condition: memCtrlE carries funct3 (0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2 and 3 never taken).
  - Compare operands: srcA vs fwdB.
REQ-015 _pcSelE and redirect:
  - 0: no redirect.
  - 1: pcSrcE = branchE AND condition; target pcE+immExtE.
  - 2 (JAL): pcSrcE = 1; target pcE+immExtE.
  - 3 (JALR): pcSrcE = 1; target (srcA+immExtE) truncated to ROM_WIDTH, bit0 cleared.
REQ-016 pcSrcE SHALL be forced 0 while stallMul=1.
REQ-017 Multiply op, when isMulE=1: aluCtrlE[1:0] selects 0 MUL (low 32), 1 MULH (s×s high), 2 MULHSU (s×u high), 3 MULHU (u×u high).
  - Product is 64-bit exact.
REQ-018 Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE with isMulE=1: latch srcA/srcB and signedness, clear count, go BUSY; stallMul=1 this cycle.
  - BUSY: one shift-add step per cycle on operand magnitudes; stallMul=1; after step 32 (count=31) go DONE.
  - DONE: apply sign correction, stallMul=0, result to aluResultM at the clock edge; go IDLE unconditionally.
REQ-019 Mul latency: instruction occupies E for 34 cycles, stallMul high for 33; DONE never restarts on the still-present isMulE.
REQ-020 Bubbles: while stallMul=1, the M register SHALL load a bubble (regWriteM=0, memWriteM=0, other fields don't-care).
REQ-021 Otherwise the M register SHALL capture E-stage control, aluResultM (ALU or mul result), writeDataM, regAddr3M, pcPlus4M = pcE+4.
REQ-022 Operands are latched in IDLE, so forwarding changes during BUSY SHALL NOT affect the product.

Reset
REQ-023 rst SHALL force FSM to IDLE and count to 0, and clear all M outputs to 0.
  - Applies mid-multiplication: the partial product is discarded and stallMul=0 the next cycle.
REQ-024 stallMul and pcSrcE SHALL be 0 in the cycle after reset while isMulE=0.

Configuration
REQ-025 Macro MUL_FAST_EN controls the multiplier implementation.
  - Defined: multiply is single-cycle combinational; FSM and counter absent; stallMul tied 0; mul latency identical to ALU ops.
  - Undefined: iterative FSM per REQ-018/019.

Verification
REQ-026 ADD: srcA=7, srcB=imm -3, aluSelE=1 -> next cycle aluResultM=4, regWriteM follows regWriteE.
REQ-027 BLT: memCtrlE=4, branchE=1, _pcSelE=1, srcA=-1, fwdB=1 -> pcSrcE=1 and pcTargetE=pcE+immExtE, same cycle; srcA=2 -> pcSrcE=0.
REQ-028 MULH: 0xFFFFFFFF × 0xFFFFFFFF signed -> stallMul high 33 cycles, M bubbles throughout, then aluResultM=0x00000000; MULHU of same operands -> 0xFFFFFFFE.
REQ-029 Forwarding: fwdAE=1 with aluResultM=0x10, fwdBE=2 with resultW=0x20, SUB -> aluResultM=0xFFFFFFF0.
REQ-030 rst asserted at BUSY count 10 -> following cycle stallMul=0, all M outputs 0; new MUL 3×5 afterwards -> aluResultM=15.

Source files
------------

// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect, multiplier,
// and the E->M pipeline register.
// Build option: define MUL_FAST_EN for a single-cycle combinational
// multiplier; leave it undefined for the iterative shift-add FSM.
//
// state | meaning
// IDLE  | no multiply in flight; a new isMulE latches operands
// BUSY  | one shift-add step per cycle, 32 steps
// DONE  | sign-corrected product presented to the M register
module execute #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int RF_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWriteE,
  input  logic [1:0]            resultSelE,
  input  logic                  memWriteE,
  input  logic [1:0]            _pcSelE,
  input  logic [3:0]            aluCtrlE,
  input  logic                  aluSelE,
  input  logic [DATA_WIDTH-1:0] dout1E,
  input  logic [DATA_WIDTH-1:0] dout2E,
  input  logic [ROM_WIDTH-1:0]  pcE,
  input  logic [RF_WIDTH-1:0]   regAddr3E,
  input  logic [DATA_WIDTH-1:0] immExtE,
  input  logic                  branchE,
  input  logic [2:0]            memCtrlE,
  input  logic                  isMulE,
  input  logic [1:0]            fwdAE,
  input  logic [1:0]            fwdBE,
  input  logic [DATA_WIDTH-1:0] resultW,
  output logic                  pcSrcE,
  output logic [ROM_WIDTH-1:0]  pcTargetE,
  output logic                  stallMul,
  output logic                  regWriteM,
  output logic [1:0]            resultSelM,
  output logic                  memWriteM,
  output logic [2:0]            memCtrlM,
  output logic [DATA_WIDTH-1:0] aluResultM,
  output logic [DATA_WIDTH-1:0] writeDataM,
  output logic [RF_WIDTH-1:0]   regAddr3M,
  output logic [ROM_WIDTH-1:0]  pcPlus4M
);

  localparam int DW = DATA_WIDTH;

  logic [DW-1:0]    srcA, fwdB, srcB, aluOut, jalrSum, mulResult;
  logic [4:0]       shamt;
  logic             cond, redirect, aSigned, bSigned, useMul;
  logic [2*DW-1:0]  prod;
  logic [1:0]       opSel;

  // Forwarding muxes; code 3 is reserved and falls back to the register file
  always_comb begin
    case (fwdAE)
      2'd1:    srcA = aluResultM;
      2'd2:    srcA = resultW;
      default: srcA = dout1E;
    endcase
    case (fwdBE)
      2'd1:    fwdB = aluResultM;
      2'd2:    fwdB = resultW;
      default: fwdB = dout2E;
    endcase
    srcB  = aluSelE ? immExtE : fwdB;
    shamt = srcB[4:0];
  end

  // ALU
  always_comb begin
    aluOut = '0;
    case (aluCtrlE)
      4'd0:    aluOut = srcA + srcB;
      4'd1:    aluOut = srcA - srcB;
      4'd2:    aluOut = srcA & srcB;
      4'd3:    aluOut = srcA | srcB;
      4'd4:    aluOut = srcA ^ srcB;
      4'd5:    aluOut = srcA << shamt;
      4'd6:    aluOut = srcA >> shamt;
      4'd7:    aluOut = $signed(srcA) >>> shamt;
      4'd8:    aluOut = DW'($signed(srcA) < $signed(srcB));
      4'd9:    aluOut = DW'(srcA < srcB);
      4'd10:   aluOut = srcB;
      default: aluOut = '0;
    endcase
  end

  // Branch condition and redirect target; redirect is suppressed while stalled
  always_comb begin
    cond = 1'b0;
    case (memCtrlE)
      3'd0:    cond = (srcA == fwdB);
      3'd1:    cond = (srcA != fwdB);
      3'd4:    cond = ($signed(srcA) < $signed(fwdB));
      3'd5:    cond = ($signed(srcA) >= $signed(fwdB));
      3'd6:    cond = (srcA < fwdB);
      3'd7:    cond = (srcA >= fwdB);
      default: cond = 1'b0;
    endcase
    jalrSum   = srcA + immExtE;
    redirect  = 1'b0;
    pcTargetE = pcE + immExtE[ROM_WIDTH-1:0];
    case (_pcSelE)
      2'd1:    redirect = branchE & cond;
      2'd2:    redirect = 1'b1;
      2'd3: begin
        redirect  = 1'b1;
        pcTargetE = {jalrSum[ROM_WIDTH-1:1], 1'b0};
      end
      default: redirect = 1'b0;
    endcase
    pcSrcE = redirect & ~stallMul;
  end

  assign aSigned = (aluCtrlE[1:0] == 2'd1) || (aluCtrlE[1:0] == 2'd2);
  assign bSigned = (aluCtrlE[1:0] == 2'd1);

`ifdef MUL_FAST_EN
  logic signed [2*DW+1:0] prodWide;

  // Single-cycle multiply: sign/zero-extend each operand by one bit
  always_comb begin
    prodWide = $signed({aSigned & srcA[DW-1], srcA}) * $signed({bSigned & srcB[DW-1], srcB});
    prod     = prodWide[2*DW-1:0];
    opSel    = aluCtrlE[1:0];
    useMul   = isMulE;
    stallMul = 1'b0;
  end
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;
  localparam int CW = $clog2(DW);

  mulState_t        state, stateNext;
  logic [CW-1:0]    count;
  logic [2*DW-1:0]  mcand, acc;
  logic [DW-1:0]    mplier, magA, magB;
  logic             negRes;
  logic [1:0]       opLat;

  assign magA = (aSigned && srcA[DW-1]) ? -srcA : srcA;
  assign magB = (bSigned && srcB[DW-1]) ? -srcB : srcB;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and stall; DONE returns to IDLE even if isMulE is still high
  always_comb begin
    stateNext = state;
    stallMul  = 1'b0;
    case (state)
      IDLE: if (isMulE) begin
        stallMul  = 1'b1;
        stateNext = BUSY;
      end
      BUSY: begin
        stallMul = 1'b1;
        if (count == CW'(DW - 1)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch in IDLE, then shift-add on magnitudes in BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      negRes <= 1'b0;
      opLat  <= 2'd0;
    end else if (state == IDLE && isMulE) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= {{DW{1'b0}}, magA};
      mplier <= magB;
      negRes <= (aSigned & srcA[DW-1]) ^ (bSigned & srcB[DW-1]);
      opLat  <= aluCtrlE[1:0];
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // Sign correction applied when the result leaves the FSM
  always_comb begin
    prod   = negRes ? -acc : acc;
    opSel  = opLat;
    useMul = (state == DONE);
  end
`endif

  assign mulResult = (opSel == 2'd0) ? prod[DW-1:0] : prod[2*DW-1:DW];

  // E->M pipeline register; a stall inserts a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteM  <= 1'b0;
      resultSelM <= '0;
      memWriteM  <= 1'b0;
      memCtrlM   <= '0;
      aluResultM <= '0;
      writeDataM <= '0;
      regAddr3M  <= '0;
      pcPlus4M   <= '0;
    end else if (stallMul) begin
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
    end else begin
      regWriteM  <= regWriteE;
      resultSelM <= resultSelE;
      memWriteM  <= memWriteE;
      memCtrlM   <= memCtrlE;
      aluResultM <= useMul ? mulResult : aluOut;
      writeDataM <= fwdB;
      regAddr3M  <= regAddr3E;
      pcPlus4M   <= pcE + ROM_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: stimulus pushes expected M-stage records,
// a monitor pops and compares whenever regWriteM is presented.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteE, memWriteE, aluSelE, branchE, isMulE;
  logic [1:0]  resultSelE, pcSelE, fwdAE, fwdBE;
  logic [3:0]  aluCtrlE;
  logic [31:0] dout1E, dout2E, immExtE, resultW;
  logic [11:0] pcE;
  logic [4:0]  regAddr3E;
  logic [2:0]  memCtrlE;
  logic        pcSrcE, stallMul, regWriteM, memWriteM;
  logic [11:0] pcTargetE, pcPlus4M;
  logic [1:0]  resultSelM;
  logic [2:0]  memCtrlM;
  logic [31:0] aluResultM, writeDataM;
  logic [4:0]  regAddr3M;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [11:0] pc4;
    logic [1:0]  rsel;
    logic [2:0]  mctl;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   seq     = 0;

  execute dut (
    .clk(clk), .rst(rst), .regWriteE(regWriteE), .resultSelE(resultSelE),
    .memWriteE(memWriteE), ._pcSelE(pcSelE), .aluCtrlE(aluCtrlE), .aluSelE(aluSelE),
    .dout1E(dout1E), .dout2E(dout2E), .pcE(pcE), .regAddr3E(regAddr3E),
    .immExtE(immExtE), .branchE(branchE), .memCtrlE(memCtrlE), .isMulE(isMulE),
    .fwdAE(fwdAE), .fwdBE(fwdBE), .resultW(resultW), .pcSrcE(pcSrcE),
    .pcTargetE(pcTargetE), .stallMul(stallMul), .regWriteM(regWriteM),
    .resultSelM(resultSelM), .memWriteM(memWriteM), .memCtrlM(memCtrlM),
    .aluResultM(aluResultM), .writeDataM(writeDataM), .regAddr3M(regAddr3M),
    .pcPlus4M(pcPlus4M)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWriteE = 0; resultSelE = 0; memWriteE = 0; pcSelE = 0; aluCtrlE = 0;
    aluSelE = 0; dout1E = 0; dout2E = 0; pcE = 0; regAddr3E = 0; immExtE = 0;
    branchE = 0; memCtrlE = 0; isMulE = 0; fwdAE = 0; fwdBE = 0; resultW = 0;
  endtask

  // Sets the per-instruction control fields and pushes the expected record
  task automatic setCtl(input logic [31:0] expAlu, input logic [31:0] expWd);
    exp_t e;
    seq++;
    regWriteE  = 1'b1;
    memWriteE  = 1'b0;
    regAddr3E  = 5'(seq);
    pcE        = 12'(seq * 8);
    resultSelE = 2'(seq);
    memCtrlE   = 3'(seq);
    e.alu  = expAlu;
    e.wd   = expWd;
    e.rd   = 5'(seq);
    e.pc4  = 12'(seq * 8 + 4);
    e.rsel = 2'(seq);
    e.mctl = 3'(seq);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, b, imm,
                       input logic sel, input logic [1:0] fa, fb,
                       input logic [31:0] rw, expAlu, expWd);
    setCtl(expAlu, expWd);
    aluCtrlE = ctrl; dout1E = a; dout2E = b; immExtE = imm; aluSelE = sel;
    fwdAE = fa; fwdBE = fb; resultW = rw;
    tick();
    idle();
  endtask

  // Multiply: counts stall cycles, checks bubbles and redirect suppression,
  // and scrambles the register-file operands while BUSY
  task automatic runMul(input logic [1:0] op, input logic [31:0] a, b, expAlu);
    int n = 0;
    int bad = 0;
    setCtl(expAlu, b);
    isMulE = 1'b1; aluCtrlE = {2'b00, op}; dout1E = a; dout2E = b; pcSelE = 2'd2;
    #1;
    while (stallMul && n < 40) begin
      if (pcSrcE) bad++;
      tick();
      n++;
      if (regWriteM || memWriteM) bad++;
      dout1E = $urandom;
      dout2E = $urandom;
    end
    dout1E = a;
    dout2E = b;
    chk("mul_stall_cycles", 64'(n), 64'd33);
    chk("mul_bubbles_redirect", 64'(bad), 64'd0);
    tick();
    idle();
  endtask

  // Monitor: every presented M-stage write is compared against the scoreboard
  always @(negedge clk) begin
    if (!rst && regWriteM) begin
      if (sb.size() == 0) begin
        chk("m_unexpected_write", 64'(aluResultM), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_aluResult", 64'(aluResultM), 64'(e.alu));
        chk("m_fields", 64'({resultSelM, memWriteM, memCtrlM, regAddr3M, pcPlus4M, writeDataM}),
            64'({e.rsel, 1'b0, e.mctl, e.rd, e.pc4, e.wd}));
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_outputs",
        64'({regWriteM, memWriteM, resultSelM, memCtrlM, regAddr3M, pcPlus4M, aluResultM | writeDataM}),
        64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_stall_redirect", 64'({stallMul, pcSrcE}), 64'd0);

    // ALU vectors
    issue(4'd0, 32'd7, 32'h55, 32'hFFFF_FFFD, 1'b1, 2'd0, 2'd0, 0, 32'd4, 32'h55);
    issue(4'd1, 32'd5, 32'd7, 0, 1'b0, 2'd0, 2'd0, 0, 32'hFFFF_FFFE, 32'd7);
    issue(4'd2, 32'hF0F0, 32'hFF00, 0, 1'b0, 2'd0, 2'd0, 0, 32'hF000, 32'hFF00);
    issue(4'd3, 32'hF0F0, 32'hFF00, 0, 1'b0, 2'd0, 2'd0, 0, 32'hFFF0, 32'hFF00);
    issue(4'd4, 32'hF0F0, 32'hFF00, 0, 1'b0, 2'd0, 2'd0, 0, 32'h0FF0, 32'hFF00);
    issue(4'd5, 32'd1, 32'd9, 32'd33, 1'b1, 2'd0, 2'd0, 0, 32'd2, 32'd9);
    issue(4'd6, 32'h8000_0000, 32'd4, 0, 1'b0, 2'd0, 2'd0, 0, 32'h0800_0000, 32'd4);
    issue(4'd7, 32'h8000_0000, 32'd4, 0, 1'b0, 2'd0, 2'd0, 0, 32'hF800_0000, 32'd4);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 2'd0, 2'd0, 0, 32'd1, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 2'd0, 2'd0, 0, 32'd0, 32'd1);
    issue(4'd10, 32'd3, 32'd8, 32'h1234, 1'b1, 2'd0, 2'd0, 0, 32'h1234, 32'd8);
    issue(4'd12, 32'd3, 32'd8, 0, 1'b0, 2'd0, 2'd0, 0, 32'd0, 32'd8);

    // Forwarding: aluResultM = 0x10, resultW = 0x20, SUB -> 0xFFFFFFF0
    issue(4'd0, 32'h10, 32'd0, 32'd0, 1'b1, 2'd0, 2'd0, 0, 32'h10, 32'd0);
    issue(4'd1, 32'hDEAD, 32'hBEEF, 0, 1'b0, 2'd1, 2'd2, 32'h20, 32'hFFFF_FFF0, 32'h20);
    issue(4'd0, 32'd1, 32'd2, 0, 1'b0, 2'd3, 2'd3, 32'h99, 32'd3, 32'd2);

    // Branch / jump redirect (combinational)
    pcSelE = 2'd1; branchE = 1'b1; memCtrlE = 3'd4; pcE = 12'h100; immExtE = 32'h20;
    dout1E = 32'hFFFF_FFFF; dout2E = 32'd1;
    #1 chk("blt_taken", 64'({pcSrcE, pcTargetE}), 64'({1'b1, 12'h120}));
    dout1E = 32'd2;
    #1 chk("blt_not_taken", 64'(pcSrcE), 64'd0);
    memCtrlE = 3'd7;
    #1 chk("bgeu_taken", 64'(pcSrcE), 64'd1);
    memCtrlE = 3'd0; dout1E = 32'd5; dout2E = 32'd5;
    #1 chk("beq_taken", 64'(pcSrcE), 64'd1);
    memCtrlE = 3'd1;
    #1 chk("bne_not_taken", 64'(pcSrcE), 64'd0);
    memCtrlE = 3'd2;
    #1 chk("funct3_2_never", 64'(pcSrcE), 64'd0);
    memCtrlE = 3'd0; branchE = 1'b0;
    #1 chk("branchE_low", 64'(pcSrcE), 64'd0);
    pcSelE = 2'd2; immExtE = 32'hFFFF_FFF0;
    #1 chk("jal", 64'({pcSrcE, pcTargetE}), 64'({1'b1, 12'h0F0}));
    pcSelE = 2'd3; dout1E = 32'h203; immExtE = 32'h10;
    #1 chk("jalr", 64'({pcSrcE, pcTargetE}), 64'({1'b1, 12'h212}));
    pcSelE = 2'd0;
    #1 chk("no_redirect", 64'(pcSrcE), 64'd0);
    tick();
    idle();

    // Multiplies
    runMul(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    runMul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runMul(2'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    runMul(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

    // Reset at BUSY count 10 discards the multiply
    regWriteE = 1'b1; isMulE = 1'b1; aluCtrlE = 4'd0;
    dout1E = 32'h1234_5678; dout2E = 32'd9; regAddr3E = 5'd7; pcE = 12'h80;
    tick();
    repeat (10) tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_mul_stall", 64'(stallMul), 64'd0);
    chk("rst_mid_mul_m_zero",
        64'({regWriteM, memWriteM, resultSelM, memCtrlM, regAddr3M, pcPlus4M, aluResultM | writeDataM}),
        64'd0);
    runMul(2'd0, 32'd3, 32'd5, 32'd15);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
